// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, link-state encoding and control-code helper for the
// receive link monitor.
package xgmii_pkg;

    localparam int XGMII_LANES  = 8;
    localparam int XGMII_LANE_W = 9;

    localparam logic [7:0] CTRL_IDLE  = 8'h07;
    localparam logic [7:0] CTRL_START = 8'hFB;
    localparam logic [7:0] CTRL_TERM  = 8'hFD;
    localparam logic [7:0] CTRL_SEQ   = 8'h9C;
    localparam logic [7:0] CTRL_ERROR = 8'hFE;

    localparam logic [7:0] LF_CODE = 8'h01;
    localparam logic [7:0] RF_CODE = 8'h02;

    typedef enum logic [1:0] {
        ST_DOWN   = 2'd0,
        ST_UP     = 2'd1,
        ST_LFAULT = 2'd2,
        ST_RFAULT = 2'd3
    } link_state_t;

    typedef enum logic {
        FT_LOCAL  = 1'b0,
        FT_REMOTE = 1'b1
    } fault_type_t;

    // A control octet is acceptable only if it is one of the known non-error codes.
    function automatic logic ctrl_known(input logic [7:0] o);
        return (o != CTRL_ERROR) &&
               ((o == CTRL_IDLE) || (o == CTRL_START) ||
                (o == CTRL_TERM) || (o == CTRL_SEQ));
    endfunction

endpackage

// File: rtl/xgmii_word_classify.sv
// Combinational classifier for one 8-lane XGMII word: local fault set,
// remote fault set (checked at lanes 0 and 4) and error word.
module xgmii_word_classify
    import xgmii_pkg::*;
(
    input  logic [XGMII_LANES*XGMII_LANE_W-1:0] word,
    output logic                                is_lf,
    output logic                                is_rf,
    output logic                                is_err
);

    logic [XGMII_LANES-1:0] lane_bad;

    // Sequence ordered set starting at the given base lane with the given fault code.
    function automatic logic seq_at(input logic [XGMII_LANES*XGMII_LANE_W-1:0] w,
                                    input int base, input logic [7:0] code);
        return (w[base*XGMII_LANE_W       +: XGMII_LANE_W] == {1'b1, CTRL_SEQ}) &&
               (w[(base+1)*XGMII_LANE_W   +: XGMII_LANE_W] == {1'b0, 8'h00})   &&
               (w[(base+2)*XGMII_LANE_W   +: XGMII_LANE_W] == {1'b0, 8'h00})   &&
               (w[(base+3)*XGMII_LANE_W   +: XGMII_LANE_W] == {1'b0, code});
    endfunction

    for (genvar i = 0; i < XGMII_LANES; i++) begin : g_lane
        assign lane_bad[i] = word[i*XGMII_LANE_W+8] && !ctrl_known(word[i*XGMII_LANE_W +: 8]);
    end

    assign is_lf  = seq_at(word, 0, LF_CODE) || seq_at(word, 4, LF_CODE);
    assign is_rf  = seq_at(word, 0, RF_CODE) || seq_at(word, 4, RF_CODE);
    assign is_err = |lane_bad;

endmodule

// File: rtl/xgmii_link_monitor.sv
// Receive-side XGMII link-status monitor: two-stage pipeline (register input,
// then classify and update FSM/counters). Observe-only.
// Optional error-character counter enabled by defining XGMII_LINK_MON_ERRCNT_EN;
// otherwise err_count reads 0 and err_clear is ignored.
module xgmii_link_monitor
    import xgmii_pkg::*;
#(
    parameter int UP_COUNT     = 255,
    parameter int FAULT_SEQS   = 4,
    parameter int FAULT_WINDOW = 128
) (
    input  logic                                clk_156mhz,
    input  logic                                rst_156mhz,
    input  logic                                phy_rx_ready,
    input  logic [XGMII_LANES*XGMII_LANE_W-1:0] xgmii_rx_dc,
    input  logic                                err_clear,
    output logic                                link_up,
    output logic                                local_fault,
    output logic                                remote_fault,
    output logic [1:0]                          link_state,
    output logic [15:0]                         err_count
);

    localparam logic [15:0] UC16 = 16'(UP_COUNT);
    localparam logic [15:0] FS16 = 16'(FAULT_SEQS);
    localparam logic [15:0] FW16 = 16'(FAULT_WINDOW);

    logic [XGMII_LANES*XGMII_LANE_W-1:0] word_d, word_q;
    logic        rdy_d, rdy_q;
    link_state_t state_d, state_q;
    fault_type_t ftype_d, ftype_q;
    logic [15:0] clean_d, clean_q;
    logic [15:0] fseq_d, fseq_q;
    logic [15:0] gap_d, gap_q;
    logic        link_up_d, link_up_q;
    logic        lf_d, lf_q;
    logic        rf_d, rf_q;

    logic        is_lf, is_rf, is_err;
    logic        seen_f;
    fault_type_t seen_t;

    xgmii_word_classify u_classify (
        .word   (word_q),
        .is_lf  (is_lf),
        .is_rf  (is_rf),
        .is_err (is_err)
    );

    // Stage 1 next values: straight capture of the PHY word and ready.
    always_comb begin
        word_d = xgmii_rx_dc;
        rdy_d  = phy_rx_ready;
    end

    // Stage 1 input registers.
    always_ff @(posedge clk_156mhz) begin
        if (rst_156mhz) begin
            word_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            rdy_q  <= rdy_d;
        end
    end

    // Stage 2: fault-set tracking, clean-word run length and link FSM next state.
    always_comb begin
        state_d = state_q;
        ftype_d = ftype_q;
        clean_d = clean_q;
        fseq_d  = fseq_q;
        gap_d   = gap_q;
        seen_f  = is_lf || is_rf;
        // local wins when both halves carry a fault set
        seen_t  = is_lf ? FT_LOCAL : FT_REMOTE;

        if (seen_f) begin
            if (seen_t == ftype_q && gap_q < FW16) begin
                fseq_d = (fseq_q >= FS16) ? fseq_q : fseq_q + 16'd1;
            end else begin
                fseq_d  = 16'd1;
                ftype_d = seen_t;
            end
            gap_d = '0;
        end else if (gap_q < FW16) begin
            gap_d = gap_q + 16'd1;
        end

        // A fault condition is raised only by the set that completes the run,
        // so a stale count cannot block the fault-clear timeout.
        if (seen_f && fseq_d >= FS16) begin
            state_d = (seen_t == FT_LOCAL) ? ST_LFAULT : ST_RFAULT;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    if (is_err) begin
                        clean_d = '0;
                    end else if (!seen_f) begin
                        clean_d = (clean_q == 16'hFFFF) ? clean_q : clean_q + 16'd1;
                        if (clean_d >= UC16) state_d = ST_UP;
                    end
                end
                ST_UP: ;
                default: begin
                    if (gap_d >= FW16) begin
                        state_d = ST_DOWN;
                        fseq_d  = '0;
                    end
                end
            endcase
        end

        // The clean run only matters while DOWN; any exit restarts it.
        if (state_d != ST_DOWN) clean_d = '0;

        if (!rdy_q) begin
            state_d = ST_DOWN;
            clean_d = '0;
            fseq_d  = '0;
            gap_d   = '0;
        end

        link_up_d = (state_d == ST_UP);
        lf_d      = (state_d == ST_LFAULT);
        rf_d      = (state_d == ST_RFAULT);
    end

    // Stage 2 state, counters and registered status outputs.
    always_ff @(posedge clk_156mhz) begin
        if (rst_156mhz) begin
            state_q   <= ST_DOWN;
            ftype_q   <= FT_LOCAL;
            clean_q   <= '0;
            fseq_q    <= '0;
            gap_q     <= '0;
            link_up_q <= 1'b0;
            lf_q      <= 1'b0;
            rf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ftype_q   <= ftype_d;
            clean_q   <= clean_d;
            fseq_q    <= fseq_d;
            gap_q     <= gap_d;
            link_up_q <= link_up_d;
            lf_q      <= lf_d;
            rf_q      <= rf_d;
        end
    end

    assign link_up      = link_up_q;
    assign local_fault  = lf_q;
    assign remote_fault = rf_q;
    assign link_state   = state_q;

`ifdef XGMII_LINK_MON_ERRCNT_EN
    logic [15:0] err_d, err_q;

    // Saturating error-word counter; clear wins, held while the PHY is not ready.
    always_comb begin
        err_d = err_q;
        if (err_clear) begin
            err_d = '0;
        end else if (rdy_q && is_err && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_156mhz) begin
        if (rst_156mhz) err_q <= '0;
        else            err_q <= err_d;
    end

    assign err_count = err_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign err_count        = '0;
`endif

endmodule
